// File: rtl/render_pixel_top.sv
// Pixel renderer: VGA timing, gradient background, and a square moved by debounced buttons.
// The timing fields are parameters so that a scaled-down raster can be built; the defaults
// give standard 640x480@60 Hz from a 100 MHz clock.
module render_pixel_top #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned STEP            = 4,
    parameter int unsigned SQ_SIZE         = 32,
    parameter int unsigned H_VISIBLE       = 640,
    parameter int unsigned H_FRONT         = 16,
    parameter int unsigned H_SYNC          = 96,
    parameter int unsigned H_BACK          = 48,
    parameter int unsigned V_VISIBLE       = 480,
    parameter int unsigned V_FRONT         = 10,
    parameter int unsigned V_SYNC          = 2,
    parameter int unsigned V_BACK          = 33
) (
    input  logic       clk,
    input  logic       RSTN,
    input  logic [3:0] BTN_Y,
    output logic       BTN_X4,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic [3:0] vga_red,
    output logic [3:0] vga_green,
    output logic [3:0] vga_blue
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    localparam logic [9:0]         SQ_X_INIT = 10'((H_VISIBLE - SQ_SIZE) / 2);
    localparam logic [9:0]         SQ_Y_INIT = 10'((V_VISIBLE - SQ_SIZE) / 2);
    localparam logic [10:0]        SQ_SPAN   = 11'(SQ_SIZE - 1);
    localparam logic signed [11:0] X_MAX     = 12'(H_VISIBLE - SQ_SIZE);
    localparam logic signed [11:0] Y_MAX     = 12'(V_VISIBLE - SQ_SIZE);
    localparam logic signed [11:0] STEP_S    = 12'(STEP);

    localparam int unsigned        CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       div;
    logic             pe;
    logic [9:0]       h;
    logic [9:0]       v;
    logic             frame_end;
    logic [9:0]       sq_x;
    logic [9:0]       sq_y;
    logic [3:0]       btn_meta;
    logic [3:0]       btn_sync;
    logic [3:0]       btn_db;
    logic [CNT_W-1:0] db_cnt [4];
    logic             up_held;
    logic             down_held;
    logic             left_held;
    logic             right_held;
    logic signed [11:0] x_next;
    logic signed [11:0] y_next;
    logic             in_visible;
    logic             in_square;
    logic [3:0]       red_next;
    logic [3:0]       green_next;
    logic [3:0]       blue_next;

    assign BTN_X4 = 1'b0;

    // Pixel enable strobe and end-of-frame marker derived from the divider and counters.
    always_comb begin
        pe        = (div == 2'd3);
        frame_end = pe && (h == H_LAST) && (v == V_LAST);
    end

    // Clock divider plus horizontal/vertical raster counters.
    always_ff @(posedge clk) begin
        if (RSTN) begin
            div <= '0;
            h   <= '0;
            v   <= '0;
        end else begin
            div <= div + 2'd1;
            if (pe) begin
                if (h == H_LAST) begin
                    h <= '0;
                    v <= (v == V_LAST) ? '0 : v + 10'd1;
                end else begin
                    h <= h + 10'd1;
                end
            end
        end
    end

    // Two-flop synchronizer and per-button stability counter; buttons are active-low.
    always_ff @(posedge clk) begin
        if (RSTN) begin
            btn_meta <= '1;
            btn_sync <= '1;
            btn_db   <= '1;
            for (int unsigned i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            btn_meta <= BTN_Y;
            btn_sync <= btn_meta;
            for (int unsigned i = 0; i < 4; i++) begin
                if (btn_sync[i] != btn_db[i]) begin
                    if (db_cnt[i] == CNT_LAST) begin
                        btn_db[i] <= btn_sync[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Next square position: opposing directions cancel, result saturates at the screen edges.
    always_comb begin
        up_held    = ~btn_db[0];
        down_held  = ~btn_db[1];
        left_held  = ~btn_db[2];
        right_held = ~btn_db[3];
        x_next = $signed({2'b00, sq_x});
        y_next = $signed({2'b00, sq_y});
        if (left_held && !right_held)      x_next = x_next - STEP_S;
        else if (right_held && !left_held) x_next = x_next + STEP_S;
        if (up_held && !down_held)         y_next = y_next - STEP_S;
        else if (down_held && !up_held)    y_next = y_next + STEP_S;
        if (x_next < 12'sd0)      x_next = '0;
        else if (x_next > X_MAX)  x_next = X_MAX;
        if (y_next < 12'sd0)      y_next = '0;
        else if (y_next > Y_MAX)  y_next = Y_MAX;
    end

    // Square position updates once per frame on the last pixel of the raster.
    always_ff @(posedge clk) begin
        if (RSTN) begin
            sq_x <= SQ_X_INIT;
            sq_y <= SQ_Y_INIT;
        end else if (frame_end) begin
            sq_x <= 10'(x_next);
            sq_y <= 10'(y_next);
        end
    end

    // Colour of the pixel currently addressed by (h,v): blank, square, or gradient.
    always_comb begin
        in_visible = (h < H_VIS_END) && (v < V_VIS_END);
        in_square  = ({1'b0, h} >= {1'b0, sq_x}) && ({1'b0, h} <= {1'b0, sq_x} + SQ_SPAN) &&
                     ({1'b0, v} >= {1'b0, sq_y}) && ({1'b0, v} <= {1'b0, sq_y} + SQ_SPAN);
        red_next   = '0;
        green_next = '0;
        blue_next  = '0;
        if (in_visible) begin
            if (in_square) begin
                red_next   = '1;
                green_next = '1;
                blue_next  = '1;
            end else begin
                red_next   = h[9:6];
                green_next = v[8:5];
                blue_next  = h[5:2] ^ v[5:2];
            end
        end
    end

    // Registered video outputs, one pixel behind the counters.
    always_ff @(posedge clk) begin
        if (RSTN) begin
            vga_hs    <= 1'b1;
            vga_vs    <= 1'b1;
            vga_red   <= '0;
            vga_green <= '0;
            vga_blue  <= '0;
        end else if (pe) begin
            vga_hs    <= !((h >= HS_FIRST) && (h <= HS_LAST));
            vga_vs    <= !((v >= VS_FIRST) && (v <= VS_LAST));
            vga_red   <= red_next;
            vga_green <= green_next;
            vga_blue  <= blue_next;
        end
    end

endmodule

// File: tb/tb_render_pixel_top.sv
// Bench for render_pixel_top: a full-size instance checks line timing and gradient,
// a scaled-raster instance checks frame timing, movement, clamping and reset.
module tb_render_pixel_top;

    localparam int S_FRAME = 32 * 16 * 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_f, rst_s;
    logic [3:0] btn_f, btn_s;
    logic       x4_f, hs_f, vs_f, x4_s, hs_s, vs_s;
    logic [3:0] r_f, g_f, b_f, r_s, g_s, b_s;
    logic [13:0] out_f, out_s;
    assign out_f = {hs_f, vs_f, r_f, g_f, b_f};
    assign out_s = {hs_s, vs_s, r_s, g_s, b_s};

    render_pixel_top #(.DEBOUNCE_CYCLES(4)) dut_full (
        .clk(clk), .RSTN(rst_f), .BTN_Y(btn_f), .BTN_X4(x4_f),
        .vga_hs(hs_f), .vga_vs(vs_f), .vga_red(r_f), .vga_green(g_f), .vga_blue(b_f)
    );

    render_pixel_top #(
        .DEBOUNCE_CYCLES(4), .STEP(3), .SQ_SIZE(4),
        .H_VISIBLE(24), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
        .V_VISIBLE(12), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) dut_small (
        .clk(clk), .RSTN(rst_s), .BTN_Y(btn_s), .BTN_X4(x4_s),
        .vga_hs(hs_s), .vga_vs(vs_s), .vga_red(r_s), .vga_green(g_s), .vga_blue(b_s)
    );

    int checks = 0;
    int errors = 0;

    // reference raster state for both instances
    int fdiv, fh, fv;
    int sdiv, sh, sv, ssx, ssy;
    logic [3:0] mbtn;
    logic [13:0] qf[$];
    logic [13:0] qs[$];
    bit have_f, have_s;
    logic [13:0] ef, es;

    function automatic logic [13:0] exp_pix(input int h, input int v, input int sx, input int sy,
                                            input int hv, input int hfp, input int hsw,
                                            input int vv, input int vfp, input int vsw, input int sq);
        logic [9:0] hb, vb;
        logic hs, vs;
        logic [3:0] r, g, b;
        hb = h[9:0];
        vb = v[9:0];
        hs = !(h >= hv + hfp && h < hv + hfp + hsw);
        vs = !(v >= vv + vfp && v < vv + vfp + vsw);
        if (h >= hv || v >= vv) begin
            r = 4'h0; g = 4'h0; b = 4'h0;
        end else if (h >= sx && h < sx + sq && v >= sy && v < sy + sq) begin
            r = 4'hF; g = 4'hF; b = 4'hF;
        end else begin
            r = hb[9:6];
            g = vb[8:5];
            b = hb[5:2] ^ vb[5:2];
        end
        return {hs, vs, r, g, b};
    endfunction

    // Advance one clock: update the reference rasters, queue the expected pixel on each
    // pixel strobe, then pop it 1 time unit after the edge when the DUT has produced it.
    task automatic tick();
        @(posedge clk);
        if (rst_f) begin
            fdiv = 0; fh = 0; fv = 0;
            qf.delete();
        end else begin
            if (fdiv == 3) begin
                qf.push_back(exp_pix(fh, fv, 304, 224, 640, 16, 96, 480, 10, 2, 32));
                fh++;
                if (fh == 800) begin
                    fh = 0;
                    fv = (fv == 524) ? 0 : fv + 1;
                end
            end
            fdiv = (fdiv + 1) % 4;
        end
        if (rst_s) begin
            sdiv = 0; sh = 0; sv = 0; ssx = 10; ssy = 4;
            qs.delete();
        end else begin
            if (sdiv == 3) begin
                qs.push_back(exp_pix(sh, sv, ssx, ssy, 24, 2, 4, 12, 1, 2, 4));
                if (sh == 31 && sv == 15) begin
                    if (!mbtn[0] && mbtn[1]) ssy = (ssy - 3 < 0) ? 0 : ssy - 3;
                    if (!mbtn[1] && mbtn[0]) ssy = (ssy + 3 > 8) ? 8 : ssy + 3;
                    if (!mbtn[2] && mbtn[3]) ssx = (ssx - 3 < 0) ? 0 : ssx - 3;
                    if (!mbtn[3] && mbtn[2]) ssx = (ssx + 3 > 20) ? 20 : ssx + 3;
                end
                sh++;
                if (sh == 32) begin
                    sh = 0;
                    sv = (sv == 15) ? 0 : sv + 1;
                end
            end
            sdiv = (sdiv + 1) % 4;
        end
        #1;
        have_f = (qf.size() > 0);
        if (have_f) ef = qf.pop_front();
        have_s = (qs.size() > 0);
        if (have_s) es = qs.pop_front();
    endtask

    task automatic set_btn(input logic [3:0] b);
        btn_s = b;
        mbtn  = b;
    endtask

    task automatic test_reset();
        rst_f = 1'b1; rst_s = 1'b1;
        btn_f = 4'hF;
        set_btn(4'hF);
        repeat (3) tick();
        checks++;
        if (out_f !== 14'b11_0000_0000_0000) begin
            errors++; $display("FAIL reset_full got %h expected %h", out_f, 14'b11_0000_0000_0000);
        end
        checks++;
        if (out_s !== 14'b11_0000_0000_0000) begin
            errors++; $display("FAIL reset_small got %h expected %h", out_s, 14'b11_0000_0000_0000);
        end
        checks++;
        if ({x4_f, x4_s} !== 2'b00) begin
            errors++; $display("FAIL btn_x4_reset got %b expected 00", {x4_f, x4_s});
        end
    endtask

    task automatic test_hsync();
        int t_fall1 = -1;
        int t_rise1 = -1;
        int t_fall2 = -1;
        logic prev_hs = 1'b1;
        rst_f = 1'b0;
        for (int t = 1; t <= 6400; t++) begin
            tick();
            if (have_f) begin
                checks++;
                if (out_f !== ef) begin
                    errors++; $display("FAIL hsync_pixel t=%0d got %h expected %h", t, out_f, ef);
                end
            end
            if (prev_hs && !hs_f) begin
                if (t_fall1 < 0) t_fall1 = t;
                else if (t_fall2 < 0) t_fall2 = t;
            end
            if (!prev_hs && hs_f && t_rise1 < 0) t_rise1 = t;
            prev_hs = hs_f;
        end
        checks++;
        if (t_fall1 != 2628) begin
            errors++; $display("FAIL hs_first_fall got %0d expected 2628", t_fall1);
        end
        checks++;
        if (t_rise1 != 3012) begin
            errors++; $display("FAIL hs_first_rise got %0d expected 3012", t_rise1);
        end
        checks++;
        if (t_fall2 != 5828) begin
            errors++; $display("FAIL hs_second_fall got %0d expected 5828", t_fall2);
        end
        rst_f = 1'b1;
    endtask

    task automatic test_frame_timing();
        int t_fall1 = -1;
        int t_rise1 = -1;
        int t_fall2 = -1;
        logic prev_vs = 1'b1;
        rst_s = 1'b0;
        for (int t = 1; t <= 2 * S_FRAME; t++) begin
            tick();
            if (have_s) begin
                checks++;
                if (out_s !== es) begin
                    errors++; $display("FAIL frame_pixel t=%0d got %h expected %h", t, out_s, es);
                end
            end
            if (prev_vs && !vs_s) begin
                if (t_fall1 < 0) t_fall1 = t;
                else if (t_fall2 < 0) t_fall2 = t;
            end
            if (!prev_vs && vs_s && t_rise1 < 0) t_rise1 = t;
            prev_vs = vs_s;
        end
        checks++;
        if (t_fall1 != 1668) begin
            errors++; $display("FAIL vs_first_fall got %0d expected 1668", t_fall1);
        end
        checks++;
        if (t_rise1 != 1924) begin
            errors++; $display("FAIL vs_first_rise got %0d expected 1924", t_rise1);
        end
        checks++;
        if (t_fall2 != 3716) begin
            errors++; $display("FAIL vs_second_fall got %0d expected 3716", t_fall2);
        end
    endtask

    task automatic test_move_right();
        set_btn(4'b0111);
        for (int i = 0; i < 5 * S_FRAME; i++) begin
            tick();
            if (have_s) begin
                checks++;
                if (out_s !== es) begin
                    errors++; $display("FAIL move_right_pixel i=%0d got %h expected %h", i, out_s, es);
                end
            end
        end
        set_btn(4'hF);
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 2 * S_FRAME; i++) begin
            tick();
            if (i == 1000) btn_s[3] = 1'b0;
            if (i == 1002) btn_s[3] = 1'b1;
            if (have_s) begin
                checks++;
                if (out_s !== es) begin
                    errors++; $display("FAIL glitch_pixel i=%0d got %h expected %h", i, out_s, es);
                end
            end
        end
    endtask

    task automatic test_clamp_left();
        set_btn(4'b1011);
        for (int i = 0; i < 8 * S_FRAME; i++) begin
            tick();
            if (have_s) begin
                checks++;
                if (out_s !== es) begin
                    errors++; $display("FAIL clamp_left_pixel i=%0d got %h expected %h", i, out_s, es);
                end
            end
        end
        set_btn(4'hF);
    endtask

    task automatic test_up_down();
        set_btn(4'b1100);
        for (int i = 0; i < 5 * S_FRAME; i++) begin
            if (i == 2 * S_FRAME) set_btn(4'b1101);
            tick();
            if (have_s) begin
                checks++;
                if (out_s !== es) begin
                    errors++; $display("FAIL up_down_pixel i=%0d got %h expected %h", i, out_s, es);
                end
            end
        end
        set_btn(4'hF);
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 1012; i++) begin
            tick();
            if (have_s) begin
                checks++;
                if (out_s !== es) begin
                    errors++; $display("FAIL pre_reset_pixel i=%0d got %h expected %h", i, out_s, es);
                end
            end
        end
        rst_s = 1'b1;
        tick();
        checks++;
        if (out_s !== 14'b11_0000_0000_0000) begin
            errors++; $display("FAIL mid_reset_outputs got %h expected %h", out_s, 14'b11_0000_0000_0000);
        end
        rst_s = 1'b0;
        for (int i = 0; i < S_FRAME; i++) begin
            tick();
            if (have_s) begin
                checks++;
                if (out_s !== es) begin
                    errors++; $display("FAIL post_reset_pixel i=%0d got %h expected %h", i, out_s, es);
                end
            end
        end
        checks++;
        if ({x4_f, x4_s} !== 2'b00) begin
            errors++; $display("FAIL btn_x4_end got %b expected 00", {x4_f, x4_s});
        end
    endtask

    initial begin
        test_reset();
        test_hsync();
        test_frame_timing();
        test_move_right();
        test_glitch();
        test_clamp_left();
        test_up_down();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/render_pixel_top.md
Name: render_pixel_top

Overview:
- Top-level pixel renderer for the board: generates 640x480@60 Hz VGA timing from the 100 MHz system clock.
- Draws a coordinate-derived background gradient plus a 32x32 white square.
- The square's position is moved by four debounced push-buttons read through a one-column keypad interface (BTN_X4 drive, BTN_Y sense).

Parameters:
- DEBOUNCE_CYCLES, 1000000, clk cycles a button must be stable before its debounced state changes (10 ms at 100 MHz).
- STEP, 4, pixels the square moves per frame while a direction is held.
- SQ_SIZE, 32, square edge length in pixels.

Ports:
- clk  input  1  100 MHz system clock; all logic on rising edge.
- RSTN  input  1  synchronous, active-high reset (1 = reset).
- BTN_Y  input  4  keypad row sense, active-low (0 = pressed); [0]=up, [1]=down, [2]=left, [3]=right.
- BTN_X4  output  1  keypad column drive; constant 0.
- vga_hs  output  1  horizontal sync, active-low.
- vga_vs  output  1  vertical sync, active-low.
- vga_red  output  4  red intensity.
- vga_green  output  4  green intensity.
- vga_blue  output  4  blue intensity.

Behaviour:
- Pixel enable (pe):
  - 2-bit divider div increments every clk; pe = (div==3), i.e. one pe per 4 clk.
  - Reset clears div; the first pe is the 4th clk after reset deasserts.
- Counters advance only on pe:
  - h counts 0..799 then wraps.
  - v increments when h wraps and counts 0..524 then wraps.
- Horizontal timing: visible 0-639, front porch 640-655, sync 656-751, back porch 752-799.
- Vertical timing: visible 0-479, front porch 480-489, sync 490-491, back porch 492-524.
- Outputs:
  - All outputs except BTN_X4 are registered and updated on pe from the current (h,v), so every output lags the counters by exactly one pixel.
  - vga_hs = 0 iff 656<=h<=751; vga_vs = 0 iff 490<=v<=491.
- Colour, first matching rule wins:
  - Outside visible area: rgb = 0.
  - Inside square (sq_x<=h<=sq_x+31 and sq_y<=v<=sq_y+31): rgb = F,F,F.
  - Otherwise: red = h[9:6], green = v[8:5], blue = h[5:2] XOR v[5:2].
- Reset values: div=0, h=0, v=0, vga_hs=1, vga_vs=1, rgb=0, sq_x=304, sq_y=224, all debounced buttons released.
- Button path:
  - Each BTN_Y bit passes a 2-flop synchronizer, then a per-button counter.
  - When the synchronized value differs from the debounced state, the counter increments each clk; when they are equal, it clears.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced state takes the new value and the counter clears.
- Movement:
  - Evaluated once per frame, on the pe where h==799 and v==524.
  - Up held: sq_y -= STEP. Down held: sq_y += STEP. Left held: sq_x -= STEP. Right held: sq_x += STEP.
  - Up+down both held: no vertical move. Left+right both held: no horizontal move.
- Clamping: sq_x within 0..608, sq_y within 0..448. A move that would cross a limit saturates at the limit (no wrap). Compute with signed or widened arithmetic so underflow is detected.
- Square position is only read for rendering; the position change becomes visible from the next frame's first pixel.
- Reset asserted mid-frame: the next clk restores all reset values; timing restarts at h=0, v=0.

Test Plan:
1. Reset held 3 clk, then released -> vga_hs=1, vga_vs=1, rgb=0 during reset. First hs falling edge at clk (656+1)*4 after the first pe. Hs low for exactly 384 clk; hs period 3200 clk.
2. Free run with no buttons -> vga_vs period 1,680,000 clk, low width 6400 clk. rgb=0 whenever the registered h>=640 or v>=480.
3. Sample pixel (h=0,v=0) -> rgb=0,0,0. Pixel (h=320,v=100) -> white? no: outside square, so red=5, green=3, blue=(0 XOR 9)=9. Pixel (h=304,v=224) -> F,F,F. Pixel (h=336,v=224) -> gradient, not white.
4. DEBOUNCE_CYCLES=4, BTN_Y=4'b0111 (right) held 10 frames -> sq_x = 304, 308, ... 344 at successive frame boundaries. Glitch of 2 clk on BTN_Y[3] -> no move.
5. DEBOUNCE_CYCLES=4, left held 100 frames -> sq_x decrements by 4 per frame and saturates at 0. Right held 200 frames -> saturates at 608. Up+down together -> sq_y stays 224.
6. Reset asserted mid-frame after square moved -> sq_x=304, sq_y=224, h=v=0, outputs back to reset values next clk; BTN_X4=0 throughout.
